// File: rtl/ysyx_23060208_lsu_if.sv
// AXI-lite bus bundle between the LSU (master) and the dsram arbiter port (slave).
interface ysyx_23060208_lsu_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/ysyx_23060208_lsu.sv
// Load/store unit: one EXU request -> one AXI-lite transaction -> one registered write-back result.
module ysyx_23060208_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [REG_WIDTH-1:0]  req_rd,
  ysyx_23060208_lsu_if.master   bus,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [REG_WIDTH-1:0]  wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_wen,
  output logic                  wb_err,
  output logic                  lsu_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RADDR  = 3'd1;
  localparam logic [2:0] S_RDATA  = 3'd2;
  localparam logic [2:0] S_WADDR  = 3'd3;
  localparam logic [2:0] S_WRESP  = 3'd4;
  localparam logic [2:0] S_RESULT = 3'd5;

  logic [2:0]            state;
  logic [1:0]            off_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic                  aw_done;
  logic                  w_done;

  logic [DATA_WIDTH-1:0] awaddr_q;
  logic                  awvalid_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            wstrb_q;
  logic                  wvalid_q;
  logic                  bready_q;
  logic [DATA_WIDTH-1:0] araddr_q;
  logic                  arvalid_q;
  logic                  rready_q;

  assign bus.awaddr  = awaddr_q;
  assign bus.awvalid = awvalid_q;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = wstrb_q;
  assign bus.wvalid  = wvalid_q;
  assign bus.bready  = bready_q;
  assign bus.araddr  = araddr_q;
  assign bus.arvalid = arvalid_q;
  assign bus.rready  = rready_q;

  assign req_ready = (state == S_IDLE);

  logic                  misaligned;
  logic [DATA_WIDTH-1:0] store_data;
  logic [3:0]            store_strb;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  aw_fin;
  logic                  w_fin;

  always_comb begin
    misaligned = (req_size == 2'd1 && req_addr[0]) ||
                 (req_size[1] && req_addr[1:0] != 2'b00);
    case (req_size)
      2'd0: begin
        store_data = {4{req_wdata[7:0]}};
        store_strb = 4'b0001 << req_addr[1:0];
      end
      2'd1: begin
        store_data = {2{req_wdata[15:0]}};
        store_strb = 4'b0011 << req_addr[1:0];
      end
      default: begin
        store_data = req_wdata;
        store_strb = 4'b1111;
      end
    endcase
  end

  // Read data arrives lane-aligned; shift the addressed bytes down before extending.
  always_comb begin
    shifted = bus.rdata >> {off_q, 3'b000};
    case (size_q)
      2'd0:    load_data = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      2'd1:    load_data = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // A channel counts as finished if it completed earlier or is handshaking this cycle.
  assign aw_fin = aw_done | (awvalid_q & bus.awready);
  assign w_fin  = w_done  | (wvalid_q  & bus.wready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      off_q     <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      awaddr_q  <= '0;
      awvalid_q <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      wb_wen    <= 1'b0;
      wb_err    <= 1'b0;
      lsu_done  <= 1'b0;
    end else begin
      lsu_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            off_q  <= req_addr[1:0];
            size_q <= req_size;
            uns_q  <= req_unsigned;
            wb_rd  <= req_rd;
            if (misaligned) begin
              state    <= S_RESULT;
              wb_valid <= 1'b1;
              wb_err   <= 1'b1;
              wb_wen   <= 1'b0;
              wb_data  <= '0;
            end else if (req_we) begin
              state     <= S_WADDR;
              awaddr_q  <= req_addr;
              awvalid_q <= 1'b1;
              wdata_q   <= store_data;
              wstrb_q   <= store_strb;
              wvalid_q  <= 1'b1;
              aw_done   <= 1'b0;
              w_done    <= 1'b0;
            end else begin
              state     <= S_RADDR;
              araddr_q  <= req_addr;
              arvalid_q <= 1'b1;
            end
          end
        end
        S_RADDR: begin
          if (bus.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (bus.rvalid) begin
            rready_q <= 1'b0;
            lsu_done <= 1'b1;
            wb_valid <= 1'b1;
            state    <= S_RESULT;
            if (bus.rresp != 2'b00) begin
              wb_err  <= 1'b1;
              wb_wen  <= 1'b0;
              wb_data <= '0;
            end else begin
              wb_err  <= 1'b0;
              wb_wen  <= (wb_rd != '0);
              wb_data <= load_data;
            end
          end
        end
        S_WADDR: begin
          if (awvalid_q && bus.awready) begin
            awvalid_q <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (wvalid_q && bus.wready) begin
            wvalid_q <= 1'b0;
            w_done   <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            bready_q <= 1'b1;
            state    <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (bus.bvalid) begin
            bready_q <= 1'b0;
            lsu_done <= 1'b1;
            wb_valid <= 1'b1;
            wb_wen   <= 1'b0;
            wb_data  <= '0;
            wb_err   <= (bus.bresp != 2'b00);
            state    <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060208_lsu.sv
// Randomized bench for the LSU: a reactive AXI-lite slave plus an arithmetic reference model.
module tb_ysyx_23060208_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [4:0]  req_rd = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_wen;
  logic        wb_err;
  logic        lsu_done;

  int unsigned total = 0;
  int unsigned bad = 0;

  ysyx_23060208_lsu_if bus ();

  ysyx_23060208_lsu #(.DATA_WIDTH(32), .REG_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_rd(req_rd),
    .bus(bus),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_wen(wb_wen), .wb_err(wb_err), .lsu_done(lsu_done)
  );

  always #5 clk = ~clk;

  function automatic bit is_mis(input logic [31:0] addr, input logic [1:0] size);
    if (size == 2'd0) return 1'b0;
    if (size == 2'd1) return (addr % 2) != 0;
    return (addr % 4) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] addr,
                                           input logic [1:0] size, input logic uns);
    longint v;
    v = longint'(rdata) / (longint'(1) << (8 * (addr % 4)));
    if (size == 2'd0) begin
      v = v % 256;
      if (!uns && v >= 128) v = v - 256;
    end else if (size == 2'd1) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v - 65536;
    end
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d, input logic [1:0] size);
    if (size == 2'd0) return (d % 256) * 32'h0101_0101;
    if (size == 2'd1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [3:0] ref_wstrb(input logic [31:0] addr, input logic [1:0] size);
    int unsigned nb;
    nb = (size >= 2) ? 4 : (1 << size);
    if (nb == 4) return 4'hF;
    return 4'((((1 << nb) - 1) << (addr % 4)));
  endfunction

  task automatic bus_idle();
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = '0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rresp = '0; bus.rdata = '0;
  endtask

  task automatic run_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                          input logic [4:0] rd, input logic [31:0] rdata, input logic [1:0] rresp,
                          input int unsigned ar_wait, input int unsigned r_wait,
                          input int unsigned wb_wait);
    bit mis, got, exp_err, exp_wen;
    logic [31:0] exp_data;
    int unsigned c, ar_cnt, r_cnt, done_cnt, ar_seen;
    mis = is_mis(addr, size);
    exp_err = mis || (rresp != 2'b00);
    exp_wen = !exp_err && (rd != 5'd0);
    exp_data = exp_err ? 32'h0 : ref_load(rdata, addr, size, uns);
    got = 0; ar_cnt = 0; r_cnt = 0; done_cnt = 0; ar_seen = 0;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL ld_ready: got %b exp 1", req_ready); end
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_size = size;
    req_unsigned = uns; req_rd = rd; req_wdata = $urandom;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_rd = 5'($urandom);
    for (c = 1; c <= 200; c++) begin
      if (c > 1) @(negedge clk);
      bus.arready = 1'b0; bus.rvalid = 1'b0;
      if (lsu_done) done_cnt++;
      if (wb_valid) begin got = 1; break; end
      if (bus.arvalid) begin
        ar_seen++;
        total++;
        if (bus.araddr !== addr) begin bad++; $display("FAIL ld_araddr: got %h exp %h", bus.araddr, addr); end
        if (ar_cnt == ar_wait) bus.arready = 1'b1; else ar_cnt++;
      end
      if (bus.rready) begin
        if (r_cnt == r_wait) begin
          bus.rvalid = 1'b1; bus.rdata = rdata; bus.rresp = rresp;
        end else r_cnt++;
      end
    end
    total++;
    if (!got) begin bad++; $display("FAIL ld_timeout: got no wb_valid exp wb_valid within 200 cycles"); end
    if (!mis && ar_wait == 0 && r_wait == 0) begin
      total++;
      if (c != 3) begin bad++; $display("FAIL ld_latency: got %0d exp 3", c); end
    end
    total++;
    if (mis ? (ar_seen != 0) : (ar_seen == 0)) begin bad++; $display("FAIL ld_arvalid_seen: got %0d mis %b", ar_seen, mis); end
    total++;
    if (done_cnt != (mis ? 0 : 1)) begin bad++; $display("FAIL ld_done_cnt: got %0d exp %0d", done_cnt, mis ? 0 : 1); end
    total++;
    if (wb_err !== exp_err) begin bad++; $display("FAIL ld_err: got %b exp %b", wb_err, exp_err); end
    total++;
    if (wb_wen !== exp_wen) begin bad++; $display("FAIL ld_wen: got %b exp %b", wb_wen, exp_wen); end
    total++;
    if (wb_rd !== rd) begin bad++; $display("FAIL ld_rd: got %0d exp %0d", wb_rd, rd); end
    if (!mis) begin
      total++;
      if (wb_data !== exp_data) begin bad++; $display("FAIL ld_data: got %h exp %h (addr %h size %0d uns %b rdata %h)", wb_data, exp_data, addr, size, uns, rdata); end
    end
    for (int i = 0; i < int'(wb_wait); i++) begin
      @(negedge clk);
      bus.rvalid = 1'b0; bus.arready = 1'b0;
      total++;
      if (wb_valid !== 1'b1 || req_ready !== 1'b0 || lsu_done !== 1'b0 || wb_err !== exp_err ||
          wb_wen !== exp_wen || wb_rd !== rd || (!mis && wb_data !== exp_data)) begin
        bad++;
        $display("FAIL ld_stall_hold: got v%b rdy%b done%b err%b wen%b rd%0d data%h exp v1 rdy0 done0 err%b wen%b rd%0d data%h",
                 wb_valid, req_ready, lsu_done, wb_err, wb_wen, wb_rd, wb_data, exp_err, exp_wen, rd, exp_data);
      end
    end
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0; bus_idle();
    total++;
    if (wb_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL ld_release: got wb_valid %b req_ready %b exp 0 1", wb_valid, req_ready);
    end
  endtask

  task automatic run_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data,
                           input logic [1:0] bresp, input int unsigned aw_wait,
                           input int unsigned w_wait, input int unsigned b_wait,
                           input bit check_aw_first);
    bit mis, got, aw_pend, w_pend, aw_done, w_done;
    logic [31:0] exp_wd;
    logic [3:0]  exp_st;
    int unsigned c, aw_cnt, w_cnt, b_cnt, done_cnt, aw_cyc, w_cyc, seen;
    mis = is_mis(addr, size);
    exp_wd = ref_wdata(data, size);
    exp_st = ref_wstrb(addr, size);
    got = 0; aw_pend = 0; w_pend = 0; aw_done = 0; w_done = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; done_cnt = 0; aw_cyc = 0; w_cyc = 0; seen = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_size = size;
    req_wdata = data; req_unsigned = 1'($urandom); req_rd = 5'($urandom);
    @(negedge clk);
    req_valid = 1'b0; req_wdata = $urandom;
    for (c = 1; c <= 200; c++) begin
      if (c > 1) @(negedge clk);
      bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
      if (aw_pend) begin aw_done = 1; aw_pend = 0; aw_cyc = c; end
      if (w_pend)  begin w_done = 1;  w_pend = 0;  w_cyc = c;  end
      if (lsu_done) done_cnt++;
      if (wb_valid) begin got = 1; break; end
      if (bus.awvalid || bus.wvalid || bus.bready) seen++;
      if (!mis) begin
        total++;
        if (bus.awvalid !== !aw_done || bus.wvalid !== !w_done) begin
          bad++; $display("FAIL st_valid_hold: got aw %b w %b exp aw %b w %b", bus.awvalid, bus.wvalid, !aw_done, !w_done);
        end
        total++;
        if (bus.bready !== (aw_done && w_done)) begin
          bad++; $display("FAIL st_bready: got %b exp %b", bus.bready, aw_done && w_done);
        end
      end
      if (bus.awvalid) begin
        total++;
        if (bus.awaddr !== addr) begin bad++; $display("FAIL st_awaddr: got %h exp %h", bus.awaddr, addr); end
        if (aw_cnt == aw_wait) begin bus.awready = 1'b1; aw_pend = 1; end else aw_cnt++;
      end
      if (bus.wvalid) begin
        total++;
        if (bus.wdata !== exp_wd || bus.wstrb !== exp_st) begin
          bad++; $display("FAIL st_wdata: got %h/%b exp %h/%b", bus.wdata, bus.wstrb, exp_wd, exp_st);
        end
        if (w_cnt == w_wait) begin bus.wready = 1'b1; w_pend = 1; end else w_cnt++;
      end
      if (bus.bready) begin
        if (b_cnt == b_wait) begin bus.bvalid = 1'b1; bus.bresp = bresp; end else b_cnt++;
      end
    end
    total++;
    if (!got) begin bad++; $display("FAIL st_timeout: got no wb_valid exp wb_valid within 200 cycles"); end
    total++;
    if (mis ? (seen != 0) : (seen == 0)) begin bad++; $display("FAIL st_bus_seen: got %0d mis %b", seen, mis); end
    total++;
    if (done_cnt != (mis ? 0 : 1)) begin bad++; $display("FAIL st_done_cnt: got %0d exp %0d", done_cnt, mis ? 0 : 1); end
    if (check_aw_first) begin
      total++;
      if (!(aw_cyc > 0 && aw_cyc + 3 == w_cyc)) begin bad++; $display("FAIL st_order: got aw@%0d w@%0d exp w 3 cycles after aw", aw_cyc, w_cyc); end
    end
    total++;
    if (wb_err !== (mis || bresp != 2'b00) || wb_wen !== 1'b0 || (!mis && wb_data !== 32'h0)) begin
      bad++; $display("FAIL st_result: got err %b wen %b data %h exp err %b wen 0 data 0", wb_err, wb_wen, wb_data, mis || bresp != 2'b00);
    end
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0; bus_idle();
    total++;
    if (wb_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL st_release: got wb_valid %b req_ready %b exp 0 1", wb_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    bus_idle();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.arvalid !== 1'b0 || bus.awvalid !== 1'b0 || bus.wvalid !== 1'b0 || bus.bready !== 1'b0 ||
        bus.rready !== 1'b0 || wb_valid !== 1'b0 || lsu_done !== 1'b0 || wb_data !== 32'h0 ||
        wb_err !== 1'b0 || wb_wen !== 1'b0 || wb_rd !== 5'd0) begin
      bad++;
      $display("FAIL reset_outputs: got ar%b aw%b w%b b%b r%b v%b d%b data%h err%b wen%b rd%0d exp all 0",
               bus.arvalid, bus.awvalid, bus.wvalid, bus.bready, bus.rready, wb_valid, lsu_done,
               wb_data, wb_err, wb_wen, wb_rd);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b exp 1", req_ready); end
  endtask

  task automatic test_load_directed();
    run_load(32'h8000_0003, 2'd0, 1'b0, 5'd7, 32'h80FF_0000, 2'b00, 0, 0, 0);
    run_load(32'h8000_0002, 2'd1, 1'b1, 5'd9, 32'hBEEF_1234, 2'b00, 0, 0, 0);
    run_load(32'h8000_0004, 2'd2, 1'b0, 5'd0, 32'hCAFE_F00D, 2'b00, 1, 2, 0);
  endtask

  task automatic test_load_random();
    logic [31:0] a;
    logic [1:0]  s;
    logic [4:0]  rd;
    for (int i = 0; i < 30; i++) begin
      a = $urandom; s = 2'($urandom);
      if ($urandom_range(3) != 0) a = (s == 2'd0) ? a : (s == 2'd1) ? (a & ~32'h1) : (a & ~32'h3);
      rd = ($urandom_range(5) == 0) ? 5'd0 : 5'($urandom);
      run_load(a, s, 1'($urandom), rd, $urandom, ($urandom_range(7) == 0) ? 2'($urandom_range(3, 1)) : 2'b00,
               $urandom_range(2), $urandom_range(2), $urandom_range(2));
    end
  endtask

  task automatic test_store();
    logic [31:0] a;
    logic [1:0]  s;
    run_store(32'h8000_0002, 2'd1, 32'hABCD_1234, 2'b00, 0, 3, 0, 1);
    for (int i = 0; i < 20; i++) begin
      a = $urandom; s = 2'($urandom);
      if ($urandom_range(3) != 0) a = (s == 2'd0) ? a : (s == 2'd1) ? (a & ~32'h1) : (a & ~32'h3);
      run_store(a, s, $urandom, ($urandom_range(5) == 0) ? 2'b11 : 2'b00,
                $urandom_range(3), $urandom_range(3), $urandom_range(2), 0);
    end
  endtask

  task automatic test_misaligned();
    run_load(32'h8000_0006, 2'd2, 1'b0, 5'd5, 32'h1111_2222, 2'b00, 0, 0, 0);
    run_load(32'h8000_0001, 2'd1, 1'b1, 5'd3, 32'h1111_2222, 2'b00, 0, 0, 1);
    run_store(32'h8000_0003, 2'd1, 32'h5555_AAAA, 2'b00, 0, 0, 0, 0);
  endtask

  task automatic test_err_stall();
    run_load(32'h8000_0008, 2'd2, 1'b0, 5'd12, 32'hDEAD_BEEF, 2'b10, 0, 0, 5);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0010; req_size = 2'd2; req_rd = 5'd4;
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (bus.arvalid !== 1'b1) begin bad++; $display("FAIL rstmid_arvalid_up: got %b exp 1", bus.arvalid); end
    rst = 1'b0;
    #1;
    total++;
    if (bus.arvalid !== 1'b0 || wb_valid !== 1'b0) begin
      bad++; $display("FAIL rstmid_async: got arvalid %b wb_valid %b exp 0 0", bus.arvalid, wb_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (req_ready !== 1'b1 || wb_valid !== 1'b0 || bus.arvalid !== 1'b0 || lsu_done !== 1'b0) begin
        bad++; $display("FAIL rstmid_after: got ready %b wb_valid %b arvalid %b done %b exp 1 0 0 0",
                        req_ready, wb_valid, bus.arvalid, lsu_done);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      run_load(32'h8000_0100 + 32'(4 * i), 2'd2, 1'b0, 5'(i + 1), $urandom, 2'b00, 0, 0, 0);
      run_store(32'h8000_0200 + 32'(i), 2'd0, $urandom, 2'b00, 0, 0, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_load_directed();
    test_load_random();
    test_store();
    test_misaligned();
    test_err_stall();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
